// File: rtl/result_raster_writer.sv
// ---------------------------------------------------------------------------
// result_raster_writer
//
// Collects processed center pixels (one per transfer, raster order) into a
// ping-pong pair of line banks and streams completed rows downstream with
// start-of-frame / end-of-line / end-of-frame markers. One full row of
// downstream back-pressure is absorbed while the other bank keeps filling.
//
// Ports
//   clk          : single rising-edge clock
//   reset        : synchronous, active-high
//   in_valid     : result pixel present
//   in_ready     : writer can accept (current write bank is EMPTY)
//   in_data      : result pixel
//   in_sof       : first pixel of a frame, qualified by in_valid
//   out_valid    : output pixel present
//   out_ready    : downstream accepts the pixel
//   out_data     : output pixel
//   out_sof      : first pixel of the frame
//   out_eol      : last pixel of a row
//   out_eof      : last pixel of the frame
//   frame_err    : sticky; a misplaced in_sof was seen
//   frames_done  : frames fully emitted, wraps modulo 2^16
// ---------------------------------------------------------------------------
module result_raster_writer #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int PIXEL_DEPTH  = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_DEPTH-1:0] in_data,
    input  logic                   in_sof,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_DEPTH-1:0] out_data,
    output logic                   out_sof,
    output logic                   out_eol,
    output logic                   out_eof,
    output logic                   frame_err,
    output logic [15:0]            frames_done
);

    localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    // Same-cycle hand-over to a bank whose last pixel is being written is only
    // safe when column 0 of that bank was written in an earlier cycle.
    localparam logic BYPASS_OK = (IMAGE_WIDTH > 1);

    // The fetch happens in the cycle that leaves IDLE (or in the cycle of a
    // row's final handshake): the RAM read issued there lands in the output
    // register exactly as STREAM begins.
    typedef enum logic [0:0] {
        S_IDLE,
        S_STREAM
    } state_t;

    // Line banks (synchronous-read RAM, no reset)
    logic [PIXEL_DEPTH-1:0] bank0_q [IMAGE_WIDTH];
    logic [PIXEL_DEPTH-1:0] bank1_q [IMAGE_WIDTH];

    // Bank state: FULL flag, and "row 0 of a frame" tag per bank
    logic [1:0]    full_q,  full_d;
    logic [1:0]    first_q, first_d;

    // Write pointer
    logic          wb_q,   wb_d;
    logic [CW-1:0] wcol_q, wcol_d;
    logic [RW-1:0] wrow_q, wrow_d;

    // Read pointer and FSM
    logic          rb_q,   rb_d;
    logic [CW-1:0] rcol_q, rcol_d;
    logic [RW-1:0] rrow_q, rrow_d;
    state_t        state_q, state_d;

    logic [PIXEL_DEPTH-1:0] out_data_q;
    logic                   frame_err_q, frame_err_d;
    logic [15:0]            frames_done_q, frames_done_d;

    // Write-side decode
    logic          in_hs;
    logic          sof_misplaced;
    logic [CW-1:0] wr_col;
    logic [RW-1:0] wr_row;
    logic          wr_last;

    // Read-side decode
    logic          out_hs;
    logic          other_ready;
    logic [RW-1:0] rrow_next;
    logic          rd_en;
    logic          rd_bank;
    logic [CW-1:0] rd_col;
    logic          drain_done;

    assign in_ready = ~full_q[wb_q];
    assign in_hs    = in_valid & in_ready;

    // A misplaced sof restarts the frame: the partial row is dropped by simply
    // rewinding the write column, and this pixel becomes (0,0).
    assign sof_misplaced = in_hs & in_sof & ((wrow_q != '0) | (wcol_q != '0));
    assign wr_col        = sof_misplaced ? '0 : wcol_q;
    assign wr_row        = sof_misplaced ? '0 : wrow_q;
    assign wr_last       = in_hs & (wr_col == COL_LAST);

    assign out_valid   = (state_q == S_STREAM);
    assign out_hs      = out_valid & out_ready;
    assign out_sof     = out_valid & (rrow_q == '0) & (rcol_q == '0);
    assign out_eol     = out_valid & (rcol_q == COL_LAST);
    assign out_eof     = out_eol & (rrow_q == ROW_LAST);
    assign out_data    = out_data_q;
    assign frame_err   = frame_err_q;
    assign frames_done = frames_done_q;

    assign rrow_next = (rrow_q == ROW_LAST) ? '0 : rrow_q + RW'(1);

    // The other bank can be streamed next either because it is already FULL or
    // because its final pixel is being written right now.
    assign other_ready = full_q[~rb_q] | (BYPASS_OK & wr_last & (wb_q != rb_q));

    always_comb begin
        wb_d        = wb_q;
        wcol_d      = wcol_q;
        wrow_d      = wrow_q;
        frame_err_d = frame_err_q | sof_misplaced;
        if (in_hs) begin
            if (wr_col == COL_LAST) begin
                wb_d   = ~wb_q;
                wcol_d = '0;
                wrow_d = (wr_row == ROW_LAST) ? '0 : wr_row + RW'(1);
            end else begin
                wcol_d = wr_col + CW'(1);
                wrow_d = wr_row;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rb_d          = rb_q;
        rcol_d        = rcol_q;
        rrow_d        = rrow_q;
        frames_done_d = frames_done_q;
        rd_en         = 1'b0;
        rd_bank       = rb_q;
        rd_col        = rcol_q;
        drain_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (full_q[rb_q]) begin
                    rd_en   = 1'b1;
                    rd_col  = '0;
                    rcol_d  = '0;
                    // Re-align the row count if this bank starts a new frame
                    if (first_q[rb_q]) rrow_d = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (out_hs) begin
                    if (rcol_q != COL_LAST) begin
                        // Prefetch the next pixel so a ready sink sees 1/cycle
                        rd_en  = 1'b1;
                        rd_col = rcol_q + CW'(1);
                        rcol_d = rcol_q + CW'(1);
                    end else begin
                        drain_done = 1'b1;
                        rb_d       = ~rb_q;
                        rcol_d     = '0;
                        rrow_d     = rrow_next;
                        if (out_eof) frames_done_d = frames_done_q + 16'd1;
                        if (other_ready) begin
                            rd_en   = 1'b1;
                            rd_bank = ~rb_q;
                            rd_col  = '0;
                            if (first_q[~rb_q]) rrow_d = '0;
                            state_d = S_STREAM;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Fill and drain always touch different banks, so both updates apply.
    always_comb begin
        full_d  = full_q;
        first_d = first_q;
        if (in_hs && (wr_col == '0)) first_d[wb_q] = (wr_row == '0);
        if (wr_last)                 full_d[wb_q]  = 1'b1;
        if (drain_done)              full_d[rb_q]  = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (in_hs) begin
            if (wb_q) bank1_q[wr_col] <= in_data;
            else      bank0_q[wr_col] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q        <= '0;
            first_q       <= '0;
            wb_q          <= 1'b0;
            wcol_q        <= '0;
            wrow_q        <= '0;
            rb_q          <= 1'b0;
            rcol_q        <= '0;
            rrow_q        <= '0;
            state_q       <= S_IDLE;
            out_data_q    <= '0;
            frame_err_q   <= 1'b0;
            frames_done_q <= '0;
        end else begin
            full_q        <= full_d;
            first_q       <= first_d;
            wb_q          <= wb_d;
            wcol_q        <= wcol_d;
            wrow_q        <= wrow_d;
            rb_q          <= rb_d;
            rcol_q        <= rcol_d;
            rrow_q        <= rrow_d;
            state_q       <= state_d;
            frame_err_q   <= frame_err_d;
            frames_done_q <= frames_done_d;
            if (rd_en) out_data_q <= rd_bank ? bank1_q[rd_col] : bank0_q[rd_col];
        end
    end

endmodule
